usb_tx_nrzi_encoder: RTL

USB_TX_NRZI_ENCODER -- requirements
Module: usb_tx_nrzi_encoder

---
 rtl/usb_tx_nrzi_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/usb_tx_nrzi_encoder.sv
// USB TX line encoder: NRZI with bit stuffing and SE0/SE0/J end-of-packet; line updates on the bit_strobe edge, 1 clk after serial_in.
// Backpressure: shift_stall is held for the stuff bit so the bit timer freezes the upstream shift register.
module usb_tx_nrzi_encoder (
    input  logic clk,
    input  logic n_rst,
    input  logic bit_strobe,
    input  logic tx_active,
    input  logic serial_in,
    input  logic eop_start,
    output logic dplus_out,
    output logic dminus_out,
    output logic shift_stall,
    output logic eop_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACTIVE   = 3'd1,
        STUFF    = 3'd2,
        EOP_SE0A = 3'd3,
        EOP_SE0B = 3'd4,
        EOP_J    = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic       level, level_nxt;
    logic [2:0] ones_cnt, ones_cnt_nxt;
    logic       eop_pending, eop_pending_nxt;
    logic       dplus_nxt, dminus_nxt, shift_stall_nxt, eop_done_nxt;
    logic       enc_level;
    logic [2:0] enc_ones;
    logic       line_se0;

    always_comb begin
        enc_level = serial_in ? level : ~level;
        enc_ones  = serial_in ? ones_cnt + 3'd1 : 3'd0;
        line_se0  = ~dplus_out & ~dminus_out;
    end

    always_comb begin
        state_nxt       = state;
        level_nxt       = level;
        ones_cnt_nxt    = ones_cnt;
        eop_pending_nxt = eop_pending;
        dplus_nxt       = dplus_out;
        dminus_nxt      = dminus_out;
        shift_stall_nxt = shift_stall;
        eop_done_nxt    = 1'b0;

        if (eop_start && (state == IDLE || state == ACTIVE || state == STUFF))
            eop_pending_nxt = 1'b1;

        if (bit_strobe) begin
            case (state)
                IDLE, ACTIVE: begin
                    if (eop_pending) begin
                        state_nxt       = EOP_SE0A;
                        eop_pending_nxt = 1'b0;
                        dplus_nxt       = 1'b0;
                        dminus_nxt      = 1'b0;
                    end else if (state == ACTIVE || tx_active) begin
                        level_nxt       = enc_level;
                        ones_cnt_nxt    = enc_ones;
                        dplus_nxt       = enc_level;
                        dminus_nxt      = ~enc_level;
                        shift_stall_nxt = (enc_ones == 3'd6);
                        state_nxt       = (enc_ones == 3'd6) ? STUFF : ACTIVE;
                    end
                end
                STUFF: begin
                    level_nxt       = ~level;
                    ones_cnt_nxt    = 3'd0;
                    dplus_nxt       = ~level;
                    dminus_nxt      = level;
                    shift_stall_nxt = 1'b0;
                    if (eop_pending) begin
                        state_nxt       = EOP_SE0A;
                        eop_pending_nxt = 1'b0;
                    end else begin
                        state_nxt = ACTIVE;
                    end
                end
                EOP_SE0A: begin
                    // Arriving from STUFF the line still carries the stuff bit, so the
                    // first SE0 period starts here and SE0A is held one more strobe.
                    dplus_nxt  = 1'b0;
                    dminus_nxt = 1'b0;
                    if (line_se0)
                        state_nxt = EOP_SE0B;
                end
                EOP_SE0B: begin
                    level_nxt  = 1'b1;
                    dplus_nxt  = 1'b1;
                    dminus_nxt = 1'b0;
                    state_nxt  = EOP_J;
                end
                EOP_J: begin
                    ones_cnt_nxt = 3'd0;
                    eop_done_nxt = 1'b1;
                    state_nxt    = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            level       <= 1'b1;
            ones_cnt    <= 3'd0;
            eop_pending <= 1'b0;
            dplus_out   <= 1'b1;
            dminus_out  <= 1'b0;
            shift_stall <= 1'b0;
            eop_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            level       <= level_nxt;
            ones_cnt    <= ones_cnt_nxt;
            eop_pending <= eop_pending_nxt;
            dplus_out   <= dplus_nxt;
            dminus_out  <= dminus_nxt;
            shift_stall <= shift_stall_nxt;
            eop_done    <= eop_done_nxt;
        end
    end

endmodule
